// File: rtl/dma_bus_controller.sv
// CI-programmed DMA engine: bursts blocks between buffer port B and the system bus as bus master.
// Optional completion interrupt port dmaIrq when DMA_COMPLETE_IRQ_EN is defined.
module dma_bus_controller #(
  parameter logic [7:0] customId = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ciStart,
  input  logic [7:0]  ciN,
  input  logic [31:0] ciValueA,
  input  logic [31:0] ciValueB,
  output logic        ciDone,
  output logic [31:0] ciResult,
  output logic [8:0]  memAddress,
  output logic        memWriteEnable,
  output logic [31:0] memDataOut,
  input  logic [31:0] memDataIn,
  output logic        busRequest,
  input  logic        busGrant,
  output logic        beginTransaction,
  output logic        endTransaction,
  output logic        readNotWrite,
  output logic [7:0]  burstSize,
  output logic [31:0] addressData,
  output logic        dataValid,
  input  logic [31:0] busDataIn,
  input  logic        busDataValid,
  input  logic        busEnd,
  input  logic        busBusy,
  input  logic        busError
`ifdef DMA_COMPLETE_IRQ_EN
  ,
  output logic        dmaIrq
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_BEGIN, S_RDATA, S_WDATA, S_WEND, S_NEXT} state_t;
  state_t state_q, state_d;

  logic [31:0] bus_addr_q, cur_bus_q, wr_dat_q;
  logic [8:0]  buf_addr_q, cur_buf_q, beats_q;
  logic [9:0]  size_q, remaining_q;
  logic [7:0]  burst_q, burst_len_q;
  logic        rnw_q, wr_pend_q, done_q, error_q;

  logic        s_sel, ci_wr, busy, cfg_wr, start_req, stat_rd, in_burst;
  logic [2:0]  ci_reg;
  logic        load_burst, rd_beat, beat_w, set_done, set_err;
  logic [8:0]  beats_cfg, beats_take;
  logic [31:0] rd_val;
  logic        unused_bits;

  assign s_sel     = ciStart && (ciN == customId);
  assign ci_reg    = ciValueA[12:10];
  assign ci_wr     = ciValueA[9];
  assign busy      = (state_q != S_IDLE);
  assign cfg_wr    = s_sel && ci_wr && !busy;
  assign start_req = cfg_wr && (ci_reg == 3'd5) && (ciValueB[1:0] != 2'b00);
  assign stat_rd   = s_sel && !ci_wr && (ci_reg == 3'd5);
  assign unused_bits = ^{ciValueA[31:13], ciValueA[8:0]};

  // A burst is the smaller of the programmed burst and what is left of the block.
  assign beats_cfg  = {1'b0, burst_q} + 9'd1;
  assign beats_take = (remaining_q < {1'b0, beats_cfg}) ? remaining_q[8:0] : beats_cfg;

  always_comb begin
    state_d    = state_q;
    load_burst = 1'b0;
    rd_beat    = 1'b0;
    beat_w     = 1'b0;
    set_done   = 1'b0;
    set_err    = 1'b0;
    case (state_q)
      S_IDLE:  if (start_req && size_q != 10'd0) state_d = S_REQ;
      S_REQ:   if (busGrant) begin
                 state_d    = S_BEGIN;
                 load_burst = 1'b1;
               end
      S_BEGIN: state_d = rnw_q ? S_RDATA : S_WDATA;
      S_RDATA: begin
                 rd_beat = busDataValid && (remaining_q != 10'd0);
                 if (busEnd) state_d = S_NEXT;
               end
      S_WDATA: if (!busBusy) begin
                 beat_w = 1'b1;
                 if (beats_q == 9'd1) state_d = S_WEND;
               end
      S_WEND:  state_d = S_NEXT;
      S_NEXT:  if (remaining_q == 10'd0) begin
                 state_d  = S_IDLE;
                 set_done = 1'b1;
               end else begin
                 state_d = S_REQ;
               end
      default: state_d = S_IDLE;
    endcase
    if (busy && busError) begin
      state_d  = S_IDLE;
      set_err  = 1'b1;
      set_done = 1'b0;
      rd_beat  = 1'b0;
      beat_w   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus_addr_q <= '0; buf_addr_q <= '0; size_q <= '0; burst_q <= '0;
      cur_bus_q <= '0; cur_buf_q <= '0; remaining_q <= '0; beats_q <= '0;
      burst_len_q <= '0; rnw_q <= 1'b0; wr_pend_q <= 1'b0; wr_dat_q <= '0;
      done_q <= 1'b0; error_q <= 1'b0;
    end else begin
      if (cfg_wr) begin
        case (ci_reg)
          3'd1: bus_addr_q <= {ciValueB[31:2], 2'b00};
          3'd2: buf_addr_q <= ciValueB[8:0];
          3'd3: size_q     <= ciValueB[9:0];
          3'd4: burst_q    <= ciValueB[7:0];
          default: ;
        endcase
      end
      if (load_burst) begin
        beats_q     <= beats_take;
        burst_len_q <= beats_take[7:0] - 8'd1;
      end
      // Read beats land in the buffer one cycle after they arrive on the bus.
      wr_pend_q <= rd_beat;
      if (rd_beat) begin
        wr_dat_q    <= busDataIn;
        remaining_q <= remaining_q - 10'd1;
        cur_bus_q   <= cur_bus_q + 32'd4;
      end
      if (wr_pend_q) cur_buf_q <= cur_buf_q + 9'd1;
      if (beat_w) begin
        remaining_q <= remaining_q - 10'd1;
        cur_bus_q   <= cur_bus_q + 32'd4;
        cur_buf_q   <= cur_buf_q + 9'd1;
        beats_q     <= beats_q - 9'd1;
      end
      if (set_done) done_q  <= 1'b1;
      if (set_err)  error_q <= 1'b1;
      if (start_req) begin
        error_q     <= 1'b0;
        done_q      <= (size_q == 10'd0);
        rnw_q       <= ciValueB[0];
        cur_bus_q   <= bus_addr_q;
        cur_buf_q   <= buf_addr_q;
        remaining_q <= size_q;
      end
    end
  end

`ifdef DMA_COMPLETE_IRQ_EN
  logic irq_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                                irq_q <= 1'b0;
    else if (set_done || set_err || (start_req && size_q == 10'd0)) irq_q <= 1'b1;
    else if (start_req || stat_rd)                             irq_q <= 1'b0;
  end
  assign dmaIrq = irq_q;
`else
  logic unused_stat;
  assign unused_stat = stat_rd;
`endif

  always_comb begin
    rd_val = '0;
    case (ci_reg)
      3'd1: rd_val = bus_addr_q;
      3'd2: rd_val = {23'd0, buf_addr_q};
      3'd3: rd_val = {22'd0, size_q};
      3'd4: rd_val = {24'd0, burst_q};
      3'd5: rd_val = {29'd0, done_q, error_q, busy};
      default: rd_val = '0;
    endcase
  end

  assign ciDone   = reset && s_sel;
  assign ciResult = (reset && s_sel) ? rd_val : 32'd0;

  assign in_burst = (state_q == S_BEGIN) || (state_q == S_RDATA) ||
                    (state_q == S_WDATA) || (state_q == S_WEND);

  assign busRequest       = (state_q == S_REQ) || in_burst;
  assign beginTransaction = (state_q == S_BEGIN);
  assign endTransaction   = (state_q == S_WEND);
  assign readNotWrite     = in_burst && rnw_q;
  assign burstSize        = in_burst ? burst_len_q : 8'd0;
  assign dataValid        = (state_q == S_WDATA);
  assign memWriteEnable   = wr_pend_q;
  assign memDataOut       = wr_pend_q ? wr_dat_q : 32'd0;

  always_comb begin
    addressData = '0;
    if (state_q == S_BEGIN)      addressData = cur_bus_q;
    else if (state_q == S_WDATA) addressData = memDataIn;
  end

  // Write bursts prefetch: advance the read address only when the current beat retires.
  always_comb begin
    memAddress = '0;
    if (wr_pend_q)
      memAddress = cur_buf_q;
    else if (state_q == S_BEGIN && !rnw_q)
      memAddress = cur_buf_q;
    else if (state_q == S_WDATA)
      memAddress = (beat_w && beats_q != 9'd1) ? cur_buf_q + 9'd1 : cur_buf_q;
  end

endmodule

// File: doc/dma_bus_controller.md
# dma_bus_controller

Sequencing engine for the 512×32 dual-port DMA buffer. Configured and started through the custom-instruction (CI) interface. Moves blocks between the buffer's port B and the shared system bus as a bus master, in bursts. The CPU side keeps using port A through its own CI. This block owns port B exclusively.

## Interface
Parameters:
- customId, 8'h00, CI number this block answers to.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low; all state and outputs cleared while low.
- ciStart  in  1  CI strobe.
- ciN  in  8  CI number.
- ciValueA  in  32  register select/command.
- ciValueB  in  32  write data.
- ciDone  out  1  CI completion.
- ciResult  out  32  CI read data.
- memAddress  out  9  port B address.
- memWriteEnable  out  1  port B write strobe.
- memDataOut  out  32  port B write data.
- memDataIn  in  32  port B read data, valid one cycle after address.
- busRequest  out  1  bus request.
- busGrant  in  1  bus grant.
- beginTransaction  out  1  one-cycle transaction start.
- endTransaction  out  1  one-cycle end of a write burst.
- readNotWrite  out  1  1 = bus read (bus→buffer).
- burstSize  out  8  beats−1 of the current burst.
- addressData  out  32  address on the begin cycle, then write data.
- dataValid  out  1  write beat valid.
- busDataIn  in  32  read beat data.
- busDataValid  in  1  read beat valid.
- busEnd  in  1  slave end of a read burst.
- busBusy  in  1  slave stall; hold the current write beat.
- busError  in  1  slave error; abort.

## Operation
- Selection: s_sel = start when ciN == customId. ciDone = s_sel (combinational, same cycle). ciResult = 0 when not selected.
- CI decode: ciValueA[12:10] selects the register; ciValueA[9] = write. Writes land on the clock edge.
- Register map:
  - 1 = bus start address (32 bits; bits[1:0] forced 0).
  - 2 = buffer start address (9 bits).
  - 3 = block size in words (10 bits; 0 means no transfer).
  - 4 = burst size (8 bits; beats = value+1).
  - 5 = control on write: bit0 starts bus→buffer, bit1 starts buffer→bus, bit0 wins if both set.
  - 5 = status on read: bit0 busy, bit1 error, bit2 done.
  - Reads of registers 1–4 return the programmed value, zero-extended.
- While busy, CI writes to registers 1–5 are ignored. Status reads remain valid.
- A start clears error and done. A start with block size 0 sets done immediately and never becomes busy.
- FSM states and transitions:
  - IDLE.
  - REQ: busRequest=1 until busGrant.
  - BEGIN: one cycle, beginTransaction=1, addressData = current bus address, burstSize = min(burst, remaining)−1.
  - RDATA or WDATA: beat transfer.
  - WEND: endTransaction=1 for one cycle.
  - NEXT: if remaining = 0, go to IDLE and set done; else go to REQ.
  - busRequest drops in NEXT, so the master re-arbitrates between bursts.
- RDATA: each busDataValid writes busDataIn to the buffer on the following cycle, then increments the buffer address. busEnd moves to NEXT.
- WDATA:
  - The buffer is prefetched: the address is issued in BEGIN, and data is ready on the first WDATA cycle.
  - Each cycle with dataValid=1 and busBusy=0 completes a beat.
  - With busBusy=1, addressData and dataValid hold.
  - After the last beat, go to WEND.
- Arithmetic:
  - Bus address += 4 per beat, wrapping at 2^32.
  - Buffer address += 1 per beat, wrapping 511→0.
  - remaining −= 1 per beat.
- busError in any bus state:
  - Drop all bus outputs next cycle.
  - Set error; leave done clear.
  - Go to IDLE.
- Reset mid-transfer: everything returns to IDLE asynchronously. Registers are cleared, no pending memory write is performed, and all outputs are 0.

## Timing
- Reset value of every output is 0.
- CI access has zero wait states.
- Start (CI write) → busRequest asserted on the next cycle.
- Grant → beginTransaction on the next cycle.
- Write burst: first dataValid one cycle after beginTransaction. With no stalls, N beats take N cycles, then endTransaction for one cycle.
- Read burst: memWriteEnable pulses exactly one cycle after each busDataValid.
- A grant removed mid-burst is ignored. The slave's busEnd or busError ends the burst.
- busy is set from the cycle after the start write until the cycle NEXT/IDLE is entered with remaining = 0.

## Configuration
- DMA_COMPLETE_IRQ_EN defined:
  - Adds output port dmaIrq (1 bit, reset 0).
  - dmaIrq is set when a transfer finishes, whether done or error.
  - dmaIrq is cleared on a CI read of status, or by a new start.
- Undefined: no dmaIrq port. Completion is only visible by polling status.

## Test plan
- Reset low mid-WDATA → all outputs 0 within the reset cycle; status reads 0 after release.
- Bus→buffer: bus address 0x100, buffer address 0, size 8, burst 3 → two bursts of 4 beats with burstSize=3. Beginning addresses are 0x100 and 0x110. Buffer words 0..7 are written. Status ends at 0x4.
- Buffer→bus: buffer address 510, size 4, burst 7, busBusy high for 2 cycles on beat 2 → memAddress sequence 510, 511, 0, 1. The stalled beat is held. One burst with burstSize=3.
- busError on the 3rd read beat → bus outputs drop next cycle; status 0x2; the next start clears the error.
- CI write to register 1 while busy → value unchanged on readback; start with size 0 → status 0x4, busRequest never asserted.
- With DMA_COMPLETE_IRQ_EN: dmaIrq rises at completion and clears on the status read.
